// File: rtl/fp_normalizer.sv
// fp_normalizer: sequential post-add normalizer, one mantissa bit shift per clock.
// Ports: clk/rst (async active-high); start + sum_in (25-bit raw sum, bit 24 = carry)
// + exp_in (biased exponent) begin an operation; mant_out/exp_out carry the normalized
// result; busy is high outside IDLE; done pulses for one cycle when results are valid;
// zero/overflow/underflow describe the result and hold until the next accepted start.
module fp_normalizer #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W:0]   sum_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              overflow,
    output logic              underflow
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    state_t            state;
    logic [MANT_W:0]   work;
    logic [EXP_W-1:0]  expo;
    logic [EXP_W-1:0]  exp_inc;
    logic              finish;
    assign exp_inc = expo + 1'b1;
    // every NORM rule except the left shift ends the operation
    assign finish = (expo == EXP_MAX) || (work == '0) || work[MANT_W]
                  || work[MANT_W-1] || (expo <= 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            expo      <= '0;
            mant_out  <= '0;
            exp_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work      <= sum_in;
                        expo      <= exp_in;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        busy      <= 1'b1;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (expo == EXP_MAX) begin
                        mant_out <= '0;
                        exp_out  <= EXP_MAX;
                        overflow <= 1'b1;
                    end else if (work == '0) begin
                        mant_out <= '0;
                        exp_out  <= '0;
                        zero     <= 1'b1;
                    end else if (work[MANT_W]) begin
                        // carry: truncating right shift, saturate on exponent overflow
                        work     <= work >> 1;
                        expo     <= exp_inc;
                        mant_out <= (exp_inc == EXP_MAX) ? '0 : work[MANT_W:1];
                        exp_out  <= exp_inc;
                        overflow <= (exp_inc == EXP_MAX);
                    end else if (work[MANT_W-1]) begin
                        mant_out <= work[MANT_W-1:0];
                        exp_out  <= expo;
                    end else if (expo <= 1) begin
                        mant_out  <= work[MANT_W-1:0];
                        exp_out   <= '0;
                        underflow <= 1'b1;
                    end else begin
                        work <= work << 1;
                        expo <= expo - 1'b1;
                    end
                    if (finish) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed and random checks of fp_normalizer against an arithmetic model.
module tb_fp_normalizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [24:0] sum_in = '0;
    logic [7:0]  exp_in = '0;
    logic [23:0] mant_out;
    logic [7:0]  exp_out;
    logic        busy, done, zero, overflow, underflow;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_normalizer dut (
        .clk(clk), .rst(rst), .start(start), .sum_in(sum_in), .exp_in(exp_in),
        .mant_out(mant_out), .exp_out(exp_out), .busy(busy), .done(done),
        .zero(zero), .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Result from the arithmetic meaning of normalization: find the leading one,
    // shift it to bit 23 unless the exponent would drop below 1.
    function automatic void model(input logic [24:0] s, input int e, output logic [23:0] m,
                                  output int eo, output logic z, output logic o,
                                  output logic u, output int k);
        int p, sh;
        logic [24:0] t;
        z = 0; o = 0; u = 0; k = 0; m = '0; eo = 0; p = 0;
        if (e == 255) begin
            o = 1; eo = 255;
        end else if (s == 0) begin
            z = 1;
        end else if (s >= 25'h1000000) begin
            if (e + 1 == 255) begin
                o = 1; eo = 255;
            end else begin
                t = s / 2; m = t[23:0]; eo = e + 1;
            end
        end else begin
            for (int i = 0; i < 24; i++) if (s[i]) p = i;
            sh = 23 - p;
            if (sh == 0 || sh <= e - 1) begin
                k = sh; eo = e - sh;
            end else begin
                k = (e > 1) ? e - 1 : 0; u = 1;
            end
            t = s << k;
            m = t[23:0];
        end
    endfunction

    task automatic run(input logic [24:0] s, input logic [7:0] e, input bit hazard,
                       input string tag);
        logic [23:0] m;
        int eo, k, cycles;
        logic z, o, u;
        bit busy_ok;
        model(s, int'(e), m, eo, z, o, u, k);
        @(negedge clk);
        sum_in = s; exp_in = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0; sum_in = 25'($urandom); exp_in = 8'($urandom);
        cycles = 1;
        busy_ok = 1;
        while (done !== 1'b1 && cycles < 60) begin
            if (busy !== 1'b1) busy_ok = 0;
            start = hazard && cycles == 3;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, cycles, k + 2);
        chk({tag, ".busy_during"}, {31'b0, busy_ok}, 1);
        chk({tag, ".busy_at_done"}, {31'b0, busy}, 1);
        chk({tag, ".mant"}, {8'b0, mant_out}, {8'b0, m});
        chk({tag, ".exp"}, {24'b0, exp_out}, eo);
        chk({tag, ".flags"}, {29'b0, zero, overflow, underflow}, {29'b0, z, o, u});
        @(negedge clk);
        chk({tag, ".done_pulse"}, {30'b0, done, busy}, 0);
        chk({tag, ".hold"}, {mant_out, exp_out}, {m, 8'(eo)});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset.outputs", {mant_out, exp_out}, 0);
        chk("reset.ctrl", {27'b0, busy, done, zero, overflow, underflow}, 0);
        rst = 1'b0;
        run(25'h0800000, 8'd100, 0, "normalized");
        run(25'h0000100, 8'd100, 0, "left_shift");
        run(25'h1800001, 8'd127, 0, "carry");
        run(25'h1000000, 8'd254, 0, "ovf_inc");
        run(25'h0000123, 8'd255, 0, "ovf_max");
        run(25'h0000001, 8'd5, 0, "underflow");
        run(25'h0000000, 8'd77, 0, "zero");
        run(25'h0000100, 8'd100, 1, "start_ignored");
        run(25'h0000003, 8'd0, 0, "exp0");
        // asynchronous reset in the middle of a normalization
        @(negedge clk);
        sum_in = 25'h0000100; exp_in = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset.outputs", {mant_out, exp_out}, 0);
        chk("midreset.ctrl", {27'b0, busy, done, zero, overflow, underflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit saw_done = 0;
            repeat (20) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
            end
            chk("midreset.no_done", {31'b0, saw_done}, 0);
        end
        run(25'h0800000, 8'd100, 0, "after_reset");
        for (int i = 0; i < 40; i++) begin
            logic [24:0] s;
            logic [7:0] e;
            s = 25'($urandom) >> $urandom_range(24, 0);
            case ($urandom_range(3, 0))
                0: e = 8'($urandom_range(255, 253));
                1: e = 8'($urandom_range(4, 0));
                default: e = 8'($urandom);
            endcase
            run(s, e, bit'($urandom_range(1, 0)), "random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
